spi_slave_rx: RTL
=================

// Module: spi_slave_rx
// PURPOSE
//  Receive side of the SPI link that the test SPI master drives into main (mode 0, MSB first, cs low = frame).
//  Oversamples spi_clk/spi_cs/spi_mosi in the clk_in domain and deserializes bytes.
//  Emits one data_valid pulse per byte together with its index within the frame, plus frame start/end/error strobes.
//  Shifts tx_byte back out on spi_miso as a status byte.
//  Feeds the row/frame loader in place of the UART receiver when SPI is defined.
// PARAMETERS
//  SYNC_STAGES      2    synchronizer depth for spi_clk, spi_cs, spi_mosi (>=2)
//  MAX_FRAME_BYTES  512  bytes accepted per cs-low frame; excess bytes flagged, not delivered
//  IDX_WIDTH        $clog2(MAX_FRAME_BYTES)  width of byte_index
// PORTS
//  clk_in       in   1          system clock; spi_clk high and low phases each >= 2 clk_in cycles
//  reset        in   1          synchronous, active-high
//  spi_clk      in   1          SPI serial clock from master (async)
//  spi_cs       in   1          SPI chip select, active low (async)
//  spi_mosi     in   1          serial data from master (async)
//  spi_miso     out  1          serial data to master
//  tx_byte      in   8          status byte returned on miso; sampled at frame start and after each byte
//  data_out     out  8          last complete received byte; held until next byte
//  data_valid   out  1          1-cycle pulse: data_out/byte_index valid
//  byte_index   out  IDX_WIDTH  index of data_out within current frame (0 = first)
//  frame_start  out  1          1-cycle pulse on synchronized cs falling edge
//  frame_end    out  1          1-cycle pulse on synchronized cs rising edge
//  frame_error  out  1          1-cycle pulse coincident with frame_end if frame was partial or overflowed
//  busy         out  1          high while in SHIFT state
// BEHAVIOUR
//  Reset:
//   - all outputs 0 except spi_miso=0; data_out=0, byte_index=0.
//   - sync regs reset: cs=1, clk=0, mosi=0.
//   - state <= WAIT_IDLE.
//  Edge detect on synced signals: rise = sync & ~prev, fall = ~sync & prev. mosi goes through the same depth, so it is aligned with spi_clk.
//  States:
//   - WAIT_IDLE: ignore everything until cs_sync==1 -> IDLE. A cs held low through reset never starts a frame.
//   - IDLE: on cs fall -> SHIFT. Pulse frame_start; bit_cnt=0; byte_cnt=0; overflow=0; txsr<=tx_byte; spi_miso<=tx_byte[7].
//   - SHIFT, per spi_clk rise: rxsr<={rxsr[6:0],mosi_sync}; bit_cnt++ (3-bit, wraps 7->0).
//     - On the 8th rise, data_out<={rxsr[6:0],mosi_sync} and data_valid=1 the following cycle.
//     - byte_index<=byte_cnt, then byte_cnt++ (saturates at MAX_FRAME_BYTES).
//     - If byte_cnt==MAX_FRAME_BYTES: no data_valid, data_out unchanged, overflow=1.
//   - SHIFT, per spi_clk fall: spi_miso<=txsr[6], txsr<<=1.
//     - After the 8th fall of a byte: txsr<=tx_byte and spi_miso<=tx_byte[7].
//   - SHIFT, on cs rise -> IDLE. Pulse frame_end; frame_error=1 if bit_cnt!=0 or overflow; partial bits discarded.
//  Simultaneous events:
//   - cs rise with spi_clk rise in the same cycle: cs wins, the bit is dropped, and bit_cnt!=0 gives frame_error if the byte was partial.
//  Latency: data_valid at SYNC_STAGES+2 clk_in cycles after the 8th spi_clk rising edge reaches the pin.
//  spi_clk edges while cs high are ignored. spi_miso holds its last value between frames.
//  Reset mid-frame: abort immediately. No frame_end/error pulse. WAIT_IDLE.
// TESTING
//  1. Reset 3 cycles, idle inputs -> all outputs 0, busy=0, no pulses for 100 cycles.
//  2. Frame 0xA5 at clk_in/4 -> frame_start; data_out=0xA5, data_valid x1, byte_index=0; frame_end; frame_error=0.
//  3. Frame 0x12,0x34,0x56 back-to-back -> 3 data_valid pulses with indices 0,1,2 in order; one frame_start, one frame_end.
//  4. 5 bits then cs high -> no data_valid; frame_end and frame_error pulse together; next full 0x3C frame gets index 0.
//  5. MAX_FRAME_BYTES=2, send 0x01,0x02,0x03 -> valid for 0x01,0x02 only; data_out stays 0x02; frame_error at frame_end.
//  6. tx_byte=0xC3, 1-byte frame -> master reads 0xC3 on miso. Then assert reset mid-byte with cs low -> no frame_start until cs goes high then low again.

Source files
------------

// File: rtl/spi_slave_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx
// Description : SPI mode-0 slave receiver. Oversamples the SPI pins in clk_in,
//               deserializes MSB-first bytes and returns a status byte on MISO.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx #(
    parameter int SYNC_STAGES     = 2,
    parameter int MAX_FRAME_BYTES = 512,
    parameter int IDX_WIDTH       = $clog2(MAX_FRAME_BYTES)
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 spi_clk,
    input  logic                 spi_cs,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    input  logic [7:0]           tx_byte,
    output logic [7:0]           data_out,
    output logic                 data_valid,
    output logic [IDX_WIDTH-1:0] byte_index,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int               CNT_W       = $clog2(MAX_FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0] C_MAX_BYTES = CNT_W'(MAX_FRAME_BYTES);

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] flush_q, flush_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [7:0]             rxsr_q, rxsr_d;
    logic [7:0]             txsr_q, txsr_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic                   overflow_q, overflow_d;
    logic                   miso_q, miso_d;
    logic [7:0]             data_out_q, data_out_d;
    logic [IDX_WIDTH-1:0]   byte_index_q, byte_index_d;
    logic                   byte_done_q, byte_done_d;
    logic                   data_valid_q, data_valid_d;
    logic                   frame_start_q, frame_start_d;
    logic                   frame_end_q, frame_end_d;
    logic                   frame_error_q, frame_error_d;

    logic w_clk_s, w_cs_s, w_mosi_s;
    logic w_clk_rise, w_clk_fall, w_cs_rise, w_cs_fall;

    assign w_clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign w_cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign w_mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign w_clk_rise = w_clk_s & ~clk_prev_q;
    assign w_clk_fall = ~w_clk_s & clk_prev_q;
    assign w_cs_rise  = w_cs_s & ~cs_prev_q;
    assign w_cs_fall  = ~w_cs_s & cs_prev_q;

    always_comb begin
        state_d       = state_q;
        clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        flush_d       = {flush_q[SYNC_STAGES-2:0], 1'b1};
        clk_prev_d    = w_clk_s;
        cs_prev_d     = w_cs_s;
        rxsr_d        = rxsr_q;
        txsr_d        = txsr_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        overflow_d    = overflow_q;
        miso_d        = miso_q;
        data_out_d    = data_out_q;
        byte_index_d  = byte_index_q;
        byte_done_d   = 1'b0;
        data_valid_d  = byte_done_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            ST_WAIT_IDLE: begin
                // The synchronizer resets to cs=1, so trust cs only once every
                // stage holds a real post-reset sample; a cs held low through
                // reset must not look like a fresh falling edge.
                if (flush_q[SYNC_STAGES-1] && w_cs_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_cs_fall) begin
                    state_d       = ST_SHIFT;
                    frame_start_d = 1'b1;
                    bit_cnt_d     = 3'd0;
                    byte_cnt_d    = '0;
                    overflow_d    = 1'b0;
                    txsr_d        = tx_byte;
                    miso_d        = tx_byte[7];
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    state_d       = ST_IDLE;
                    frame_end_d   = 1'b1;
                    frame_error_d = (bit_cnt_q != 3'd0) || overflow_q;
                end else if (w_clk_rise) begin
                    rxsr_d    = {rxsr_q[6:0], w_mosi_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q == C_MAX_BYTES) begin
                            overflow_d = 1'b1;
                        end else begin
                            data_out_d   = {rxsr_q[6:0], w_mosi_s};
                            byte_index_d = byte_cnt_q[IDX_WIDTH-1:0];
                            byte_done_d  = 1'b1;
                            byte_cnt_d   = byte_cnt_q + CNT_W'(1);
                        end
                    end
                end else if (w_clk_fall) begin
                    // bit_cnt has wrapped to 0 only on the fall after a byte's 8th rise
                    if (bit_cnt_q == 3'd0) begin
                        txsr_d = tx_byte;
                        miso_d = tx_byte[7];
                    end else begin
                        miso_d = txsr_q[6];
                        txsr_d = {txsr_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= ST_WAIT_IDLE;
            clk_sync_q    <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            flush_q       <= '0;
            clk_prev_q    <= 1'b0;
            cs_prev_q     <= 1'b1;
            rxsr_q        <= 8'h00;
            txsr_q        <= 8'h00;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= '0;
            overflow_q    <= 1'b0;
            miso_q        <= 1'b0;
            data_out_q    <= 8'h00;
            byte_index_q  <= '0;
            byte_done_q   <= 1'b0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clk_sync_q    <= clk_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            flush_q       <= flush_d;
            clk_prev_q    <= clk_prev_d;
            cs_prev_q     <= cs_prev_d;
            rxsr_q        <= rxsr_d;
            txsr_q        <= txsr_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            overflow_q    <= overflow_d;
            miso_q        <= miso_d;
            data_out_q    <= data_out_d;
            byte_index_q  <= byte_index_d;
            byte_done_q   <= byte_done_d;
            data_valid_q  <= data_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign spi_miso    = miso_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign byte_index  = byte_index_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q == ST_SHIFT);

endmodule
`default_nettype wire
